// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic elastic pipeline register with a 2-entry skid buffer.
//
// Carries a payload bus and a control bus between pipeline stages using a
// valid/ready handshake. in_ready is registered, so there is no combinational
// path from out_ready to in_ready. A synchronous flush turns all held beats into
// bubbles whose control bits are zero.
//
// Optional feature (macro PIPE_STAGE_STALL_CNT_EN): adds the stall_cnt output, a
// saturating count of edges where out_valid=1 and out_ready=0. Only rst clears it.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   flush                synchronous flush, discards all held beats
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_data/in_ctrl      upstream payload and control bits
//   out_valid/out_ready  downstream handshake
//   out_data/out_ctrl    head entry payload/control (ctrl zero when not valid)
//   occupancy            number of held beats, 0..2
//   stall_cnt            backpressure counter (PIPE_STAGE_STALL_CNT_EN only)
module pipe_stage_skid #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned CTRL_W            = 9,
  parameter int unsigned CLR_DATA_ON_FLUSH = 0
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W             = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              h_valid_q, h_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] h_data_q, h_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              in_ready_q, in_ready_d;

  logic accept;
  logic drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = h_valid_q & out_ready;

  always_comb begin
    h_valid_d = h_valid_q;
    s_valid_d = s_valid_q;
    h_data_d  = h_data_q;
    s_data_d  = s_data_q;
    h_ctrl_d  = h_ctrl_q;
    s_ctrl_d  = s_ctrl_q;

    if (flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
      h_ctrl_d  = '0;
      s_ctrl_d  = '0;
      if (CLR_DATA_ON_FLUSH != 0) begin
        h_data_d = '0;
        s_data_d = '0;
      end
    end else if (!h_valid_q) begin
      // Empty: S cannot be valid without H.
      if (accept) begin
        h_valid_d = 1'b1;
        h_data_d  = in_data;
        h_ctrl_d  = in_ctrl;
      end
    end else if (!s_valid_q) begin
      if (accept && drain) begin
        h_data_d = in_data;
        h_ctrl_d = in_ctrl;
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl;
      end else if (drain) begin
        h_valid_d = 1'b0;
      end
    end else if (drain) begin
      // Full: in_ready is low so only the S-to-H move can happen.
      h_data_d  = s_data_q;
      h_ctrl_d  = s_ctrl_q;
      s_valid_d = 1'b0;
    end

    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      h_data_q   <= '0;
      s_data_q   <= '0;
      h_ctrl_q   <= '0;
      s_ctrl_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      h_valid_q  <= h_valid_d;
      s_valid_q  <= s_valid_d;
      h_data_q   <= h_data_d;
      s_data_q   <= s_data_d;
      h_ctrl_q   <= h_ctrl_d;
      s_ctrl_q   <= s_ctrl_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = h_valid_q;
  assign out_data  = h_data_q;
  assign out_ctrl  = h_ctrl_q & {CTRL_W{h_valid_q}};
  assign occupancy = {1'b0, h_valid_q} + {1'b0, s_valid_q};

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (h_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. A queue of accepted beats serves as the
// reference model; two instances share all inputs, one holding payload on flush
// and one clearing it.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 9;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          in_ready,  c_in_ready;
  logic          out_valid, c_out_valid;
  logic [DW-1:0] out_data,  c_out_data;
  logic [CW-1:0] out_ctrl,  c_out_ctrl;
  logic [1:0]    occupancy, c_occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [3:0]    stall_cnt, c_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  beat_t mq[$];
  bit    m_ready;
  int    m_stall;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .CLR_DATA_ON_FLUSH(0)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .occupancy(occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .CLR_DATA_ON_FLUSH(1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut_clr (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_ctrl(c_out_ctrl), .occupancy(c_occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(c_stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit            ev;
    logic [CW-1:0] ec;
    ev = (mq.size() > 0);
    ec = ev ? mq[0].c : '0;
    check_val("in_ready", 64'(in_ready), 64'(m_ready));
    check_val("out_valid", 64'(out_valid), 64'(ev));
    check_val("out_ctrl", 64'(out_ctrl), 64'(ec));
    check_val("occupancy", 64'(occupancy), 64'(mq.size()));
    if (ev) check_val("out_data", 64'(out_data), 64'(mq[0].d));
    check_val("clr_out_valid", 64'(c_out_valid), 64'(ev));
    check_val("clr_out_ctrl", 64'(c_out_ctrl), 64'(ec));
    if (ev) check_val("clr_out_data", 64'(c_out_data), 64'(mq[0].d));
`ifdef PIPE_STAGE_STALL_CNT_EN
    check_val("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock edge: model update from pre-edge inputs, then compare.
  task automatic step();
    bit    acc, drn, stl;
    beat_t b;
    acc = in_valid && m_ready;
    drn = (mq.size() > 0) && out_ready;
    stl = (mq.size() > 0) && !out_ready;
    b.c = in_ctrl;
    b.d = in_data;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
    if (stl && m_stall < 15) m_stall++;
    m_ready = (mq.size() < 2);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, 0, 0);
    m_ready = 0;
    m_stall = 0;
    #12;
    check_outputs();
    check_val("reset_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    step();

    // Streaming 0..9 at full rate.
    for (int i = 0; i < 10; i++) begin
      drive(1, DW'(i), CW'(i + 1), 1, 0);
      step();
      check_val("stream_data", 64'(out_data), 64'(i));
    end
    drive(0, '0, '0, 1, 0);
    step();

    // Backpressure: A then B held, then released.
    drive(1, 32'hA, 9'h3, 0, 0);
    step();
    drive(1, 32'hB, 9'h5, 0, 0);
    step();
    check_val("bp_in_ready", 64'(in_ready), 64'd0);
    drive(0, '0, '0, 1, 0);
    check_val("bp_head_a", 64'(out_data), 64'hA);
    step();
    check_val("bp_head_b", 64'(out_data), 64'hB);
    step();
    check_val("bp_ready_back", 64'(in_ready), 64'd1);

    // Mid-stream reset with two beats held.
    drive(1, 32'h11, 9'h1FF, 0, 0);
    step();
    drive(1, 32'h22, 9'h1FF, 0, 0);
    step();
    rst = 1'b1;
    #1;
    mq.delete();
    m_ready = 0;
    m_stall = 0;
    check_outputs();
    #2;
    rst = 1'b0;
    drive(0, '0, '0, 0, 0);
    step();

    // Flush when full, with a beat offered in the same cycle.
    drive(1, 32'h55, 9'h1FF, 0, 0);
    step();
    drive(1, 32'h66, 9'h1FF, 0, 0);
    step();
    drive(1, 32'h77, 9'h1FF, 0, 1);
    step();
    check_val("flush_hold_data", 64'(out_data), 64'h55);
    check_val("flush_clr_data", 64'(c_out_data), 64'h0);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    drive(0, '0, '0, 1, 0);
    step();

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter saturation, survives flush, cleared by reset.
    drive(1, 32'h99, 9'h7, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    check_val("stall_sat", 64'(stall_cnt), 64'd15);
    drive(0, '0, '0, 0, 1);
    step();
    check_val("stall_after_flush", 64'(stall_cnt), 64'd15);
    rst = 1'b1;
    #1;
    mq.delete();
    m_ready = 0;
    m_stall = 0;
    check_val("stall_reset", 64'(stall_cnt), 64'd0);
    #2;
    rst = 1'b0;
    drive(0, '0, '0, 0, 0);
    step();
`endif

    // Random traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a payload bus and a separate control bus, with a valid/ready handshake and a 2-entry skid buffer, so a stage can stall without a combinational ready path.
- Adds a synchronous flush that turns its contents into bubbles. Bubble control bits are forced to zero, so no write or branch side effects can leak downstream.

Parameters:
- DATA_W, 32: payload width (ALU result, operands, targets, ...). Range 1..256.
- CTRL_W, 9: control-bit width. These bits are forced to 0 whenever the output is not valid. Range 1..64.
- CLR_DATA_ON_FLUSH, 0: 1 = payload registers are cleared to 0 on flush; 0 = payload registers hold their value.
- CNT_W, 16: width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush; discards all held beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  registered; block can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  control bits of the head entry; all zero when out_valid=0.
- occupancy  out  2  number of held beats: 0, 1 or 2.
- stall_cnt  out  CNT_W  present only with STALL_CNT_EN.

Behaviour:
- Storage: head entry (H: valid, data, ctrl) and skid entry (S: valid, data, ctrl).
  - out_valid = H.valid; out_data = H.data; out_ctrl = H.ctrl gated by H.valid.
- Reset, asynchronous: H.valid = S.valid = 0; all data and ctrl registers = 0; in_ready = 0; stall_cnt = 0.
  - Therefore out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0.
  - in_ready rises to 1 on the first rising clk edge after rst deasserts.
- Accept: in_valid & in_ready. Drain: out_valid & out_ready. Both are evaluated at the same edge.
- Per-edge update when flush = 0:
  - Empty, accept: H takes the input. Latency is 1 cycle from acceptance to out_valid.
  - H only, accept and drain: H is replaced by the input. This gives a throughput of 1 beat/cycle.
  - H only, accept, no drain: S takes the input; occupancy becomes 2.
  - H only, drain, no accept: H.valid becomes 0.
  - H+S, drain: H takes S and S.valid becomes 0. No accept can occur in this state because in_ready = 0.
  - H+S, no drain: hold.
- in_ready is registered to the next-state value of !S.valid. It is never a combinational function of out_ready.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped, except on flush.
- Flush has priority over accept and drain at the same edge:
  - H.valid and S.valid become 0, and H.ctrl and S.ctrl become 0.
  - Payload registers are cleared to 0 if CLR_DATA_ON_FLUSH = 1, otherwise they hold.
  - A beat offered in the same cycle is discarded; upstream must be flushing too.
  - A head beat that is handshaked in the flush cycle still counts as delivered downstream.
  - in_ready = 1 on the following cycle.
- Reset asserted mid-transfer: state is cleared immediately, and any in-flight beat is lost.
- Data and ctrl registers are written only on accept or on the S-to-H move, never on idle cycles. This avoids needless toggling.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 on each edge where out_valid = 1 and out_ready = 0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by rst; flush does not clear it.
- Undefined: the port and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream with occupancy = 2 -> out_valid = 0, out_ctrl = 0, occupancy = 0 immediately; in_ready = 0, then 1 one edge after release.
- Streaming: in_valid = 1 and out_ready = 1 for 10 cycles with data = 0..9 -> out_data = 0..9 in order, each one cycle after acceptance, occupancy = 1 throughout, no bubbles.
- Backpressure: accept 0xA then 0xB with out_ready = 0 -> occupancy = 2 and in_ready = 0 on the next cycle. Raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1.
- Flush when full: occupancy = 2 with ctrl = 9'h1FF, in_valid = 1, flush = 1 -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0, the offered beat is absent, in_ready = 1. Repeat with CLR_DATA_ON_FLUSH = 1 -> out_data = 0.
- Random valid/ready at 50/50 for 10k cycles against a scoreboard -> exact in-order match, and out_ctrl = 0 whenever out_valid = 0.
- With PIPE_STAGE_STALL_CNT_EN and CNT_W = 4: hold out_valid = 1, out_ready = 0 for 20 cycles -> stall_cnt saturates at 15; flush leaves it at 15; rst clears it to 0.
